sr04_scan_ctrl: RTL
===================

# sr04_scan_ctrl

Round-robin scan scheduler for up to NUM_SENS SR04 ranging cores sharing one 50 MHz clock domain. Issues single-cycle active-low START pulses, tracks each ping via the core's TRIG output and the sensor's ECHO line, samples the core's DISTANCE after it settles, and emits one tagged result per ping. Enforces the inter-ping guard time. Recovers a hung core (no echo) by pulsing its reset.

## Interface
- NUM_SENS, 4, number of sensors served (2..8)
- ID_W, 2, width of sensor index (clog2(NUM_SENS))
- CNT_W, 24, width of guard/timeout counter
- GAP_CYC, 3_000_000, minimum cycles between successive START pulses (60 ms)
- TIMEOUT_CYC, 1_900_000, cycles after START before ping is declared lost (38 ms); must be < GAP_CYC
- TRIG_WAIT, 16, cycles after START within which TRIG must rise
- SETTLE_CYC, 4, cycles after ECHO fall before DIST_IN is sampled
- MAX_CM, 400, largest valid distance in cm
- RST_LEN, 4, cycles SENS_RST_N held low on recovery
- CLK  in  1  system clock
- RST_N  in  1  asynchronous active-low reset
- EN  in  1  level; scan continuously while high
- MASK  in  NUM_SENS  per-sensor enable, sampled at each sensor selection
- START_N  out  NUM_SENS  per-core start, active low, one-cycle pulse
- SENS_RST_N  out  NUM_SENS  per-core reset, active low
- TRIG_IN  in  NUM_SENS  per-core TRIG tap
- ECHO_IN  in  NUM_SENS  per-sensor ECHO tap, asynchronous
- DIST_IN  in  16*NUM_SENS  per-core DISTANCE, sensor i at [16i+15:16i]
- DIST_OUT  out  16  reported distance, cm
- DIST_ID  out  ID_W  sensor index of the result
- DIST_ERR  out  2  0 ok, 1 no TRIG, 2 echo timeout, 3 over range
- DIST_VALID  out  1  one-cycle result strobe
- BUSY  out  1  high in every state except IDLE

## Operation
- ECHO_IN passes through a 2-flop synchronizer per bit. Only the selected sensor's TRIG/ECHO/DIST are examined.
- States: IDLE, SELECT, START, WAIT_TRIG, WAIT_RISE, WAIT_FALL, SETTLE, REPORT, RECOVER, GAP.
- Counter `t` clears on the START cycle and counts every cycle through GAP. It saturates at all-ones.
- IDLE: if EN and |MASK, go to SELECT.
- SELECT: pick the next set MASK bit ascending from (last id + 1), wrapping. After reset, last id = NUM_SENS-1, so the first pick is the lowest set bit. If MASK is now 0, go to IDLE.
- START: drive START_N[id] low for this cycle only, then go to WAIT_TRIG.
- WAIT_TRIG: TRIG_IN[id] high goes to WAIT_RISE. If t reaches TRIG_WAIT first, set err=1 and go to RECOVER.
- WAIT_RISE: on sync echo high, go to WAIT_FALL. On t reaching TIMEOUT_CYC, set err=2 and go to RECOVER.
- WAIT_FALL: on sync echo low, go to SETTLE. Timeout is handled as in WAIT_RISE.
- SETTLE: wait SETTLE_CYC cycles, then latch DIST_IN[id].
- REPORT: one cycle with DIST_VALID=1 and DIST_ID=id.
  - If the latched value > MAX_CM: DIST_OUT=MAX_CM, DIST_ERR=3.
  - Otherwise: DIST_OUT=value, DIST_ERR=0.
- RECOVER: SENS_RST_N[id] low for RST_LEN cycles. Then a REPORT cycle with DIST_OUT=16'hFFFF and the recorded err.
- GAP: hold until t ≥ GAP_CYC-1. Then go to SELECT if EN, else IDLE. EN low mid-ping never aborts a ping; the ping completes, reports, and serves GAP.
- MASK changes affect only the next SELECT.

## Timing
- Reset values:
  - START_N and SENS_RST_N all ones.
  - DIST_OUT=0, DIST_ID=0, DIST_ERR=0, DIST_VALID=0, BUSY=0, state IDLE.
- EN rises in IDLE at cycle n: SELECT at n+1, START_N low at n+2.
- START-to-START spacing is exactly GAP_CYC+1 cycles when EN stays high.
- ECHO fall (raw) to DIST_VALID is 2 (sync) + 1 + SETTLE_CYC + 1 cycles.
- Timeout report occurs RST_LEN+1 cycles after t hits TIMEOUT_CYC.
- At most one START_N bit is low at any time; START_N and SENS_RST_N are never low for the same sensor simultaneously.
- Reset mid-ping returns to IDLE immediately. All outputs take their reset values and no result is emitted.
- ECHO already high at WAIT_RISE entry (stale echo) counts as the rise.

## Test plan
- Basic ping (GAP_CYC=2000, TIMEOUT_CYC=1500, MASK=4'b0001): core model raises TRIG 2 cycles after START and returns ECHO high 300 cycles with DIST_IN=58 → DIST_VALID, DIST_ID=0, DIST_OUT=58, DIST_ERR=0; next START_N pulse 2001 cycles after the first.
- Round robin, MASK=4'b1011: four pings served to sensors 0,1,3,0. Clearing bit 1 mid-ping of sensor 0 gives order 0,3.
- Echo lost: TRIG ok, ECHO never rises → at t=1500 SENS_RST_N[id] low 4 cycles, then DIST_VALID with DIST_OUT=16'hFFFF, DIST_ERR=2; scanning continues.
- No TRIG: TRIG_IN held 0 → err=1 report 21 cycles after START (16 + 4 + 1).
- Over range: DIST_IN=612 → DIST_OUT=400, DIST_ERR=3.
- Control edges:
  - EN drops during WAIT_FALL → that ping still reports, then IDLE after GAP with BUSY=0.
  - RST_N asserted in SETTLE → no DIST_VALID and all outputs at reset values.

Source files
------------

// File: rtl/sr04_scan_ctrl.sv
// rtl/sr04_scan_ctrl.sv - round-robin ping scheduler for a bank of SR04 ranging cores
//
// Serves up to NUM_SENS ranging cores one at a time. Each ping is a one-cycle
// active-low start pulse. The scheduler waits for the core's TRIG and the
// sensor's ECHO, samples the core's distance once it has settled, and emits
// one tagged result. A core that never triggers, or never sees an echo, is
// recovered by pulsing its reset. Successive start pulses are spaced by a
// fixed guard time.
//
// Ports:
//   clk_i          system clock
//   rst_n_i        asynchronous active-low reset
//   en_i           scan continuously while high
//   mask_i         per-sensor enable, sampled at each sensor selection
//   start_n_o      per-core start, active low, one-cycle pulse
//   sens_rst_n_o   per-core reset, active low
//   trig_i         per-core TRIG tap
//   echo_i         per-sensor ECHO tap, asynchronous
//   dist_i         per-core distance, sensor i at [16i+15:16i]
//   dist_o         reported distance in cm (16'hFFFF on a failed ping)
//   dist_id_o      sensor index of the result
//   dist_err_o     0 ok, 1 no TRIG, 2 echo timeout, 3 over range
//   dist_valid_o   one-cycle result strobe
//   busy_o         high whenever the scheduler is not idle
module sr04_scan_ctrl #(
    parameter int NUM_SENS    = 4,
    parameter int ID_W        = 2,
    parameter int CNT_W       = 24,
    parameter int GAP_CYC     = 3_000_000,
    parameter int TIMEOUT_CYC = 1_900_000,
    parameter int TRIG_WAIT   = 16,
    parameter int SETTLE_CYC  = 4,
    parameter int MAX_CM      = 400,
    parameter int RST_LEN     = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic                   en_i,
    input  logic [NUM_SENS-1:0]    mask_i,
    output logic [NUM_SENS-1:0]    start_n_o,
    output logic [NUM_SENS-1:0]    sens_rst_n_o,
    input  logic [NUM_SENS-1:0]    trig_i,
    input  logic [NUM_SENS-1:0]    echo_i,
    input  logic [16*NUM_SENS-1:0] dist_i,
    output logic [15:0]            dist_o,
    output logic [ID_W-1:0]        dist_id_o,
    output logic [1:0]             dist_err_o,
    output logic                   dist_valid_o,
    output logic                   busy_o
);

    localparam int SUB_W = 8;

    localparam logic [CNT_W-1:0] TRIG_T    = CNT_W'(TRIG_WAIT);
    localparam logic [CNT_W-1:0] TIMEOUT_T = CNT_W'(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] GAP_T     = CNT_W'(GAP_CYC - 1);
    localparam logic [SUB_W-1:0] SETTLE_LAST = SUB_W'(SETTLE_CYC - 1);
    localparam logic [SUB_W-1:0] RST_LAST    = SUB_W'(RST_LEN - 1);
    localparam logic [15:0]      MAX_D       = 16'(MAX_CM);

    typedef enum logic [3:0] {
        S_IDLE,
        S_SELECT,
        S_START,
        S_WAIT_TRIG,
        S_WAIT_RISE,
        S_WAIT_FALL,
        S_SETTLE,
        S_REPORT,
        S_RECOVER,
        S_GAP
    } state_t;

    state_t               state_q;
    logic [CNT_W-1:0]     t_q;
    logic [SUB_W-1:0]     sub_q;
    logic [ID_W-1:0]      id_q;
    logic [ID_W-1:0]      last_id_q;
    logic [1:0]           err_q;
    logic [NUM_SENS-1:0]  echo_s1_q;
    logic [NUM_SENS-1:0]  echo_s2_q;
    logic [NUM_SENS-1:0]  start_n_q;
    logic [NUM_SENS-1:0]  sens_rst_n_q;
    logic [15:0]          dist_q;
    logic [ID_W-1:0]      dist_id_q;
    logic [1:0]           dist_err_q;
    logic                 dist_valid_q;
    logic                 busy_q;

    logic [CNT_W-1:0]     t_d;
    logic [ID_W-1:0]      pick_d;
    logic [ID_W-1:0]      first_any_d;
    logic [ID_W-1:0]      first_above_d;
    logic                 above_d;
    logic                 trig_sel;
    logic                 echo_sel;
    logic [15:0]          dist_sel;

    // Guard/timeout counter saturates so a very long GAP never wraps.
    assign t_d = (&t_q) ? t_q : t_q + 1'b1;

    assign trig_sel = trig_i[id_q];
    assign echo_sel = echo_s2_q[id_q];
    assign dist_sel = dist_i[{id_q, 4'b0000} +: 16];

    // Next sensor: lowest set mask bit above the last one served, otherwise
    // wrap to the lowest set bit overall. Descending scan leaves the lowest.
    always_comb begin
        first_any_d   = '0;
        first_above_d = '0;
        above_d       = 1'b0;
        for (int k = NUM_SENS - 1; k >= 0; k--) begin
            if (mask_i[k]) begin
                first_any_d = ID_W'(k);
                if (ID_W'(k) > last_id_q) begin
                    first_above_d = ID_W'(k);
                    above_d       = 1'b1;
                end
            end
        end
        pick_d = above_d ? first_above_d : first_any_d;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            echo_s1_q <= '0;
            echo_s2_q <= '0;
        end else begin
            echo_s1_q <= echo_i;
            echo_s2_q <= echo_s1_q;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q      <= S_IDLE;
            t_q          <= '0;
            sub_q        <= '0;
            id_q         <= '0;
            last_id_q    <= ID_W'(NUM_SENS - 1);
            err_q        <= 2'd0;
            start_n_q    <= '1;
            sens_rst_n_q <= '1;
            dist_q       <= '0;
            dist_id_q    <= '0;
            dist_err_q   <= 2'd0;
            dist_valid_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            t_q          <= t_d;
            start_n_q    <= '1;
            dist_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (en_i && (|mask_i)) begin
                        state_q <= S_SELECT;
                        busy_q  <= 1'b1;
                    end
                end
                S_SELECT: begin
                    if (|mask_i) begin
                        id_q              <= pick_d;
                        last_id_q         <= pick_d;
                        start_n_q[pick_d] <= 1'b0;
                        // t reads 0 during the START cycle itself.
                        t_q               <= '0;
                        state_q           <= S_START;
                    end else begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                S_START: begin
                    state_q <= S_WAIT_TRIG;
                end
                S_WAIT_TRIG: begin
                    if (trig_sel) begin
                        state_q <= S_WAIT_RISE;
                    end else if (t_q >= TRIG_T) begin
                        err_q              <= 2'd1;
                        sens_rst_n_q[id_q] <= 1'b0;
                        sub_q              <= '0;
                        state_q            <= S_RECOVER;
                    end
                end
                S_WAIT_RISE: begin
                    // An echo already high on entry counts as the rise.
                    if (echo_sel) begin
                        state_q <= S_WAIT_FALL;
                    end else if (t_q >= TIMEOUT_T) begin
                        err_q              <= 2'd2;
                        sens_rst_n_q[id_q] <= 1'b0;
                        sub_q              <= '0;
                        state_q            <= S_RECOVER;
                    end
                end
                S_WAIT_FALL: begin
                    if (!echo_sel) begin
                        sub_q   <= '0;
                        state_q <= S_SETTLE;
                    end else if (t_q >= TIMEOUT_T) begin
                        err_q              <= 2'd2;
                        sens_rst_n_q[id_q] <= 1'b0;
                        sub_q              <= '0;
                        state_q            <= S_RECOVER;
                    end
                end
                S_SETTLE: begin
                    if (sub_q == SETTLE_LAST) begin
                        dist_valid_q <= 1'b1;
                        dist_id_q    <= id_q;
                        state_q      <= S_REPORT;
                        if (dist_sel > MAX_D) begin
                            dist_q     <= MAX_D;
                            dist_err_q <= 2'd3;
                        end else begin
                            dist_q     <= dist_sel;
                            dist_err_q <= 2'd0;
                        end
                    end else begin
                        sub_q <= sub_q + 1'b1;
                    end
                end
                S_RECOVER: begin
                    if (sub_q == RST_LAST) begin
                        sens_rst_n_q <= '1;
                        dist_valid_q <= 1'b1;
                        dist_id_q    <= id_q;
                        dist_q       <= 16'hFFFF;
                        dist_err_q   <= err_q;
                        state_q      <= S_REPORT;
                    end else begin
                        sub_q <= sub_q + 1'b1;
                    end
                end
                S_REPORT: begin
                    state_q <= S_GAP;
                end
                S_GAP: begin
                    if (t_q >= GAP_T) begin
                        if (en_i) begin
                            state_q <= S_SELECT;
                        end else begin
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign start_n_o    = start_n_q;
    assign sens_rst_n_o = sens_rst_n_q;
    assign dist_o       = dist_q;
    assign dist_id_o    = dist_id_q;
    assign dist_err_o   = dist_err_q;
    assign dist_valid_o = dist_valid_q;
    assign busy_o       = busy_q;

endmodule
